// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, pixel request and latency-matched DAC drive
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic [9:0] oVGA_X,
  output logic [8:0] oVGA_Y,
  output logic       oReq,
  output logic       oFrameStart,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0] div;
  logic tick, h_end, v_end, act, hs_n, vs_n, hs0, vs0;
  logic [2:0] dl [PIX_LAT];
  assign tick  = div == 2'(CLK_DIV - 1);
  assign h_end = hcnt == HW'(H_TOTAL - 1);
  assign v_end = vcnt == VW'(V_TOTAL - 1);
  assign act   = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
  assign hs_n  = !(hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_n  = !(vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign oVGA_SYNC_N = 1'b0;
  // pixel-tick divider and raster counters; counters move only on tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= tick ? '0 : div + 2'd1;
      if (tick) begin
        hcnt <= h_end ? '0 : hcnt + 1'b1;
        if (h_end) vcnt <= v_end ? '0 : vcnt + 1'b1;
      end
    end
  end
  // stage 0: request, coordinates and raw syncs registered on tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      oReq        <= 1'b0;
      oVGA_X      <= '0;
      oVGA_Y      <= '0;
      hs0         <= 1'b1;
      vs0         <= 1'b1;
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= tick && hcnt == '0 && vcnt == '0;
      if (tick) begin
        oReq   <= act;
        oVGA_X <= act ? 10'(hcnt) : '0;
        oVGA_Y <= act ? 9'(vcnt) : '0;
        hs0    <= hs_n;
        vs0    <= vs_n;
      end
    end
  end
  // delay {req, hs, vs} by the compositor latency, shifting every clk; idle is syncs high
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PIX_LAT; i++) dl[i] <= 3'b011;
    end else begin
      dl[0] <= {oReq, hs0, vs0};
      for (int i = 1; i < PIX_LAT; i++) dl[i] <= dl[i-1];
    end
  end
  // DAC drive: colour gated by the delayed request so blanking forces black
  always_ff @(posedge clk) begin
    if (!reset) begin
      oVGA_BLANK_N <= 1'b0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
    end else begin
      {oVGA_BLANK_N, oVGA_HS, oVGA_VS} <= dl[PIX_LAT-1];
      oVGA_R <= dl[PIX_LAT-1][2] ? iR : '0;
      oVGA_G <= dl[PIX_LAT-1][2] ? iG : '0;
      oVGA_B <= dl[PIX_LAT-1][2] ? iB : '0;
    end
  end
  // a request must stay put until its colour is sampled
  always_ff @(posedge clk) begin
    assert (CLK_DIV >= PIX_LAT) else $error("vga_timing_gen: CLK_DIV (%0d) < PIX_LAT (%0d)", CLK_DIV, PIX_LAT);
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized reset/colour stimulus on three geometries against a raster-position model
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] ir [3], ig [3], ib [3], r [3], g [3], b [3];
  logic [9:0] x [3];
  logic [8:0] y [3];
  logic req [3], fs [3], hs [3], vs [3], bn [3], sn [3];
  int pass_n = 0, total = 0, k = 0, mode = 0;
  logic [7:0] salt = 8'h00;
  int hx [3][5], hy [3][5];
  typedef struct packed {logic req; int x; int y; logic hs; logic vs;} s0_t;

  vga_timing_gen #(.CLK_DIV(2), .PIX_LAT(1)) u_a (
    .clk(clk), .reset(reset), .iR(ir[0]), .iG(ig[0]), .iB(ib[0]),
    .oVGA_X(x[0]), .oVGA_Y(y[0]), .oReq(req[0]), .oFrameStart(fs[0]),
    .oVGA_R(r[0]), .oVGA_G(g[0]), .oVGA_B(b[0]), .oVGA_HS(hs[0]), .oVGA_VS(vs[0]),
    .oVGA_BLANK_N(bn[0]), .oVGA_SYNC_N(sn[0]));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .CLK_DIV(1), .PIX_LAT(1)) u_b (
    .clk(clk), .reset(reset), .iR(ir[1]), .iG(ig[1]), .iB(ib[1]),
    .oVGA_X(x[1]), .oVGA_Y(y[1]), .oReq(req[1]), .oFrameStart(fs[1]),
    .oVGA_R(r[1]), .oVGA_G(g[1]), .oVGA_B(b[1]), .oVGA_HS(hs[1]), .oVGA_VS(vs[1]),
    .oVGA_BLANK_N(bn[1]), .oVGA_SYNC_N(sn[1]));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .CLK_DIV(4), .PIX_LAT(3)) u_c (
    .clk(clk), .reset(reset), .iR(ir[2]), .iG(ig[2]), .iB(ib[2]),
    .oVGA_X(x[2]), .oVGA_Y(y[2]), .oReq(req[2]), .oFrameStart(fs[2]),
    .oVGA_R(r[2]), .oVGA_G(g[2]), .oVGA_B(b[2]), .oVGA_HS(hs[2]), .oVGA_VS(vs[2]),
    .oVGA_BLANK_N(bn[2]), .oVGA_SYNC_N(sn[2]));

  function automatic int cd(int d);
    return d == 0 ? 2 : d == 1 ? 1 : 4;
  endfunction
  function automatic int pl(int d);
    return d == 2 ? 3 : 1;
  endfunction
  // geometry: 0 h_active, 1 h_fp, 2 h_sync, 3 h_bp, 4 v_active, 5 v_fp, 6 v_sync, 7 v_bp
  function automatic int geo(int d, int i);
    int big [8] = '{640, 16, 96, 48, 480, 10, 2, 33};
    int sm [8] = '{16, 2, 3, 4, 6, 1, 2, 1};
    return d == 0 ? big[i] : sm[i];
  endfunction
  function automatic int ht(int d);
    return geo(d, 0) + geo(d, 1) + geo(d, 2) + geo(d, 3);
  endfunction
  function automatic int vt(int d);
    return geo(d, 4) + geo(d, 5) + geo(d, 6) + geo(d, 7);
  endfunction
  // stage-0 state after the k-th clk since release: the n-th tick shows raster position n-1
  function automatic s0_t st(int d, int kk);
    s0_t s;
    int n, pos, h, v;
    s = '{req: 1'b0, x: 0, y: 0, hs: 1'b1, vs: 1'b1};
    n = kk <= 0 ? 0 : kk / cd(d);
    if (n > 0) begin
      pos = (n - 1) % (ht(d) * vt(d));
      h = pos % ht(d);
      v = pos / ht(d);
      s.req = h < geo(d, 0) && v < geo(d, 4);
      s.x = s.req ? h : 0;
      s.y = s.req ? v : 0;
      s.hs = !(h >= geo(d, 0) + geo(d, 1) && h < geo(d, 0) + geo(d, 1) + geo(d, 2));
      s.vs = !(v >= geo(d, 4) + geo(d, 5) && v < geo(d, 4) + geo(d, 5) + geo(d, 6));
    end
    return s;
  endfunction
  function automatic logic [23:0] src(int m, logic [7:0] s, int xx, int yy);
    return m == 0 ? {xx[7:0], yy[7:0], s} : m == 1 ? 24'hFFFFFF :
           {xx[7:0] ^ s, yy[7:0] + s, xx[7:0] + yy[7:0]};
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    s0_t e, o;
    logic [23:0] c;
    int n;
    logic f;
    @(posedge clk);
    #1;
    k = reset ? k + 1 : 0;
    for (int d = 0; d < 3; d++) begin
      e = st(d, k);
      o = st(d, k - pl(d) - 1);
      c = o.req ? src(mode, salt, o.x, o.y) : 24'h0;
      n = k / cd(d);
      f = k > 0 && k % cd(d) == 0 && n > 0 && (n - 1) % (ht(d) * vt(d)) == 0;
      check($sformatf("req%0d", d), req[d], e.req);
      check($sformatf("x%0d", d), x[d], e.x);
      check($sformatf("y%0d", d), y[d], e.y);
      check($sformatf("frame_start%0d", d), fs[d], f);
      check($sformatf("hs%0d", d), hs[d], o.hs);
      check($sformatf("vs%0d", d), vs[d], o.vs);
      check($sformatf("blank_n%0d", d), bn[d], o.req);
      check($sformatf("r%0d", d), r[d], c[23:16]);
      check($sformatf("g%0d", d), g[d], c[15:8]);
      check($sformatf("b%0d", d), b[d], c[7:0]);
      check($sformatf("sync_n%0d", d), sn[d], 0);
      for (int j = 4; j > 0; j--) begin
        hx[d][j] = hx[d][j-1];
        hy[d][j] = hy[d][j-1];
      end
      hx[d][0] = x[d];
      hy[d][0] = y[d];
      {ir[d], ig[d], ib[d]} = src(mode, salt, hx[d][pl(d)], hy[d][pl(d)]);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      {ir[d], ig[d], ib[d]} = 24'h0;
      for (int j = 0; j < 5; j++) begin
        hx[d][j] = 0;
        hy[d][j] = 0;
      end
    end
    repeat (4) step();
    reset = 1'b1;
    repeat (8000) step();
    for (int s = 0; s < 6; s++) begin
      mode = s < 2 ? s : int'($urandom_range(0, 2));
      salt = 8'($urandom);
      reset = 1'b0;
      repeat ($urandom_range(1, 5)) step();
      reset = 1'b1;
      repeat ($urandom_range(1500, 4000)) step();
    end
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
